// File: rtl/core_mem_stage_if.sv
// Bundle of EX-stage inputs, data-memory port and writeback outputs for the memory stage.
// The stage itself uses the master view; the surrounding pipeline/memory uses the slave view.
interface core_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic [4:0]      rd_i;
    logic            reg_write_i;
    logic            mul_sel_i;
    logic [XLEN-1:0] alu_result_i;
    logic [XLEN-1:0] store_data_i;
    logic [XLEN-1:0] mul_result_i;

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [3:0]      dmem_be_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;

    logic            stall_o;
    logic            wb_valid_o;
    logic            wb_reg_write_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            misaligned_o;

    modport master (
        input  valid_i, opcode_i, funct3_i, rd_i, reg_write_i, mul_sel_i,
               alu_result_i, store_data_i, mul_result_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
               stall_o, wb_valid_o, wb_reg_write_o, wb_rd_o, wb_data_o, misaligned_o
    );

    modport slave (
        output valid_i, opcode_i, funct3_i, rd_i, reg_write_i, mul_sel_i,
               alu_result_i, store_data_i, mul_result_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
               stall_o, wb_valid_o, wb_reg_write_o, wb_rd_o, wb_data_o, misaligned_o
    );
endinterface

// File: rtl/core_mem_stage.sv
// Pipeline memory stage: issues one data-memory access at a time, aligns load/store data,
// flags misaligned or illegal accesses and produces a registered writeback bundle.
module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    core_mem_stage_if.master bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            rw_q;
    logic            we_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;

    logic            is_load;
    logic            is_store;
    logic [1:0]      off;
    logic            bad;
    logic [3:0]      acc_be;
    logic [XLEN-1:0] acc_wdata;
    logic [XLEN-1:0] shifted;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    // Decode the incoming access: legality, byte enables and lane-replicated store data.
    always_comb begin
        is_load   = (bus.opcode_i == OP_LOAD);
        is_store  = (bus.opcode_i == OP_STORE);
        off       = bus.alu_result_i[1:0];
        bad       = 1'b0;
        acc_be    = 4'b1111;
        acc_wdata = '0;
        if (is_load) begin
            case (bus.funct3_i)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = off[0];
                3'b010:         bad = (off != 2'b00);
                default:        bad = 1'b1;
            endcase
        end else if (is_store) begin
            case (bus.funct3_i)
                3'b000: begin
                    acc_be    = 4'b0001 << off;
                    acc_wdata = {4{bus.store_data_i[7:0]}};
                end
                3'b001: begin
                    bad       = off[0];
                    acc_be    = off[1] ? 4'b1100 : 4'b0011;
                    acc_wdata = {2{bus.store_data_i[15:0]}};
                end
                3'b010: begin
                    bad       = (off != 2'b00);
                    acc_wdata = bus.store_data_i;
                end
                default: bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        shifted = bus.dmem_rdata_i >> {off_q, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = off_q[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = bus.dmem_rdata_i;
        endcase
    end

    // Single FSM: accept in IDLE, hold the request until granted, then wait for the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            addr_q             <= '0;
            off_q              <= '0;
            funct3_q           <= '0;
            rd_q               <= '0;
            rw_q               <= 1'b0;
            we_q               <= 1'b0;
            wdata_q            <= '0;
            be_q               <= '0;
            bus.wb_valid_o     <= 1'b0;
            bus.wb_reg_write_o <= 1'b0;
            bus.wb_rd_o        <= '0;
            bus.wb_data_o      <= '0;
            bus.misaligned_o   <= 1'b0;
        end else begin
            bus.wb_valid_o   <= 1'b0;
            bus.misaligned_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        if (!is_load && !is_store) begin
                            bus.wb_valid_o     <= 1'b1;
                            bus.wb_reg_write_o <= bus.reg_write_i && (bus.rd_i != 5'd0);
                            bus.wb_rd_o        <= bus.rd_i;
                            bus.wb_data_o      <= bus.mul_sel_i ? bus.mul_result_i
                                                                : bus.alu_result_i;
                        end else if (bad) begin
                            bus.wb_valid_o     <= 1'b1;
                            bus.wb_reg_write_o <= 1'b0;
                            bus.wb_rd_o        <= bus.rd_i;
                            bus.wb_data_o      <= bus.alu_result_i;
                            bus.misaligned_o   <= 1'b1;
                        end else begin
                            addr_q   <= {bus.alu_result_i[XLEN-1:2], 2'b00};
                            off_q    <= off;
                            funct3_q <= bus.funct3_i;
                            rd_q     <= bus.rd_i;
                            rw_q     <= is_load && bus.reg_write_i && (bus.rd_i != 5'd0);
                            we_q     <= is_store;
                            wdata_q  <= acc_wdata;
                            be_q     <= acc_be;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    if (bus.dmem_rvalid_i) begin
                        bus.wb_valid_o     <= 1'b1;
                        bus.wb_reg_write_o <= rw_q;
                        bus.wb_rd_o        <= rd_q;
                        bus.wb_data_o      <= we_q ? '0 : ld_data;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o      = (state != IDLE);
    assign bus.dmem_req_o   = (state == REQ);
    assign bus.dmem_we_o    = we_q;
    assign bus.dmem_addr_o  = addr_q;
    assign bus.dmem_be_o    = be_q;
    assign bus.dmem_wdata_o = wdata_q;
endmodule

// File: tb/tb_core_mem_stage.sv
// Directed-vector bench for core_mem_stage with hand-computed expectations.
module tb_core_mem_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    core_mem_stage_if #(.XLEN(32)) bus ();

    core_mem_stage #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [6:0] opcode,
                                 input logic [2:0] funct3, input logic [4:0] rd,
                                 input logic reg_write, input logic mul_sel,
                                 input logic [31:0] alu, input logic [31:0] sdata,
                                 input logic [31:0] mul);
        bus.valid_i      = valid;
        bus.opcode_i     = opcode;
        bus.funct3_i     = funct3;
        bus.rd_i         = rd;
        bus.reg_write_i  = reg_write;
        bus.mul_sel_i    = mul_sel;
        bus.alu_result_i = alu;
        bus.store_data_i = sdata;
        bus.mul_result_i = mul;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = '0;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_stall",    32'(bus.stall_o), 0);
        checkOutput("rst_req",      32'(bus.dmem_req_o), 0);
        checkOutput("rst_wb_valid", 32'(bus.wb_valid_o), 0);
        checkOutput("rst_misalign", 32'(bus.misaligned_o), 0);
        checkOutput("rst_wb_data",  bus.wb_data_o, 0);
        @(negedge clk) rst_n = 1'b1;

        // Non-memory op, one-cycle writeback
        @(negedge clk) applyStimulus(1, OP_ALU, 0, 5, 1, 0, 32'h10, 0, 0);
        checkOutput("nm_stall_pre", 32'(bus.stall_o), 0);
        tick();
        checkOutput("nm_wb_valid", 32'(bus.wb_valid_o), 1);
        checkOutput("nm_wb_data",  bus.wb_data_o, 32'h10);
        checkOutput("nm_wb_rd",    32'(bus.wb_rd_o), 5);
        checkOutput("nm_wb_rw",    32'(bus.wb_reg_write_o), 1);
        checkOutput("nm_stall",    32'(bus.stall_o), 0);
        @(negedge clk) applyStimulus(1, OP_ALU, 0, 7, 1, 1, 32'h1, 0, 32'hDEAD_BEEF);
        tick();
        checkOutput("mul_wb_data", bus.wb_data_o, 32'hDEAD_BEEF);
        checkOutput("mul_wb_rd",   32'(bus.wb_rd_o), 7);
        @(negedge clk) applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        tick();
        checkOutput("idle_wb_valid", 32'(bus.wb_valid_o), 0);
        checkOutput("idle_wb_hold",  bus.wb_data_o, 32'hDEAD_BEEF);

        // LB at 0x103, immediate grant, response next cycle
        @(negedge clk) applyStimulus(1, OP_LOAD, 3'b000, 3, 1, 0, 32'h103, 0, 0);
        tick();
        checkOutput("lb_req",      32'(bus.dmem_req_o), 1);
        checkOutput("lb_addr",     bus.dmem_addr_o, 32'h100);
        checkOutput("lb_we",       32'(bus.dmem_we_o), 0);
        checkOutput("lb_be",       32'(bus.dmem_be_o), 32'hF);
        checkOutput("lb_stall",    32'(bus.stall_o), 1);
        checkOutput("lb_wb_valid0", 32'(bus.wb_valid_o), 0);
        @(negedge clk);
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i = 1'b1;
        tick();
        checkOutput("lb_wait_req",   32'(bus.dmem_req_o), 0);
        checkOutput("lb_wait_stall", 32'(bus.stall_o), 1);
        @(negedge clk);
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h80FF_0000;
        tick();
        checkOutput("lb_wb_valid", 32'(bus.wb_valid_o), 1);
        checkOutput("lb_wb_data",  bus.wb_data_o, 32'hFFFF_FF80);
        checkOutput("lb_wb_rd",    32'(bus.wb_rd_o), 3);
        checkOutput("lb_wb_rw",    32'(bus.wb_reg_write_o), 1);
        checkOutput("lb_stall_end", 32'(bus.stall_o), 0);
        @(negedge clk) bus.dmem_rvalid_i = 1'b0;

        // SH at 0x202 with grant delayed three cycles; valid_i held high must be ignored
        @(negedge clk) applyStimulus(1, OP_STORE, 3'b001, 0, 0, 0, 32'h202, 32'h1234_ABCD, 0);
        tick();
        applyStimulus(1, OP_ALU, 0, 9, 1, 0, 32'h55, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.dmem_gnt_i = (i == 3);
            checkOutput($sformatf("sh_req_%0d", i),   32'(bus.dmem_req_o), 1);
            checkOutput($sformatf("sh_addr_%0d", i),  bus.dmem_addr_o, 32'h200);
            checkOutput($sformatf("sh_be_%0d", i),    32'(bus.dmem_be_o), 32'hC);
            checkOutput($sformatf("sh_wdata_%0d", i), bus.dmem_wdata_o, 32'hABCD_ABCD);
            checkOutput($sformatf("sh_we_%0d", i),    32'(bus.dmem_we_o), 1);
            checkOutput($sformatf("sh_stall_%0d", i), 32'(bus.stall_o), 1);
            checkOutput($sformatf("sh_wbv_%0d", i),   32'(bus.wb_valid_o), 0);
        end
        tick();
        checkOutput("sh_wait_req", 32'(bus.dmem_req_o), 0);
        @(negedge clk);
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        tick();
        checkOutput("sh_wb_valid", 32'(bus.wb_valid_o), 1);
        checkOutput("sh_wb_rw",    32'(bus.wb_reg_write_o), 0);
        @(negedge clk) bus.dmem_rvalid_i = 1'b0;
        tick();
        checkOutput("sh_wb_pulse", 32'(bus.wb_valid_o), 0);

        // SB at 0x301: lane 1 enable, byte replicated
        @(negedge clk) applyStimulus(1, OP_STORE, 3'b000, 0, 0, 0, 32'h301, 32'h0000_00A5, 0);
        tick();
        checkOutput("sb_be",    32'(bus.dmem_be_o), 32'h2);
        checkOutput("sb_wdata", bus.dmem_wdata_o, 32'hA5A5_A5A5);
        @(negedge clk);
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i = 1'b1;
        tick();
        @(negedge clk);
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        tick();
        @(negedge clk) bus.dmem_rvalid_i = 1'b0;

        // LH at 0x402: upper halfword, sign-extended
        @(negedge clk) applyStimulus(1, OP_LOAD, 3'b001, 8, 1, 0, 32'h402, 0, 0);
        tick();
        checkOutput("lh_addr", bus.dmem_addr_o, 32'h400);
        @(negedge clk);
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i = 1'b1;
        tick();
        @(negedge clk);
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h8001_7FFF;
        tick();
        checkOutput("lh_wb_data", bus.wb_data_o, 32'hFFFF_8001);
        @(negedge clk) bus.dmem_rvalid_i = 1'b0;

        // Misaligned LW at 0x101
        @(negedge clk) applyStimulus(1, OP_LOAD, 3'b010, 4, 1, 0, 32'h101, 0, 0);
        tick();
        checkOutput("lw_mis_req",   32'(bus.dmem_req_o), 0);
        checkOutput("lw_mis_stall", 32'(bus.stall_o), 0);
        checkOutput("lw_mis_pulse", 32'(bus.misaligned_o), 1);
        checkOutput("lw_mis_wbv",   32'(bus.wb_valid_o), 1);
        checkOutput("lw_mis_rw",    32'(bus.wb_reg_write_o), 0);
        @(negedge clk) applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        tick();
        checkOutput("lw_mis_clear", 32'(bus.misaligned_o), 0);
        checkOutput("lw_mis_wbv0",  32'(bus.wb_valid_o), 0);

        // Illegal store funct3 = 3
        @(negedge clk) applyStimulus(1, OP_STORE, 3'b011, 0, 0, 0, 32'h100, 32'h1, 0);
        tick();
        checkOutput("st_ill_pulse", 32'(bus.misaligned_o), 1);
        checkOutput("st_ill_req",   32'(bus.dmem_req_o), 0);

        // LW with rd = 0 must not write back
        @(negedge clk) applyStimulus(1, OP_LOAD, 3'b010, 0, 1, 0, 32'h500, 0, 0);
        tick();
        @(negedge clk);
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i = 1'b1;
        tick();
        @(negedge clk);
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h1234_5678;
        tick();
        checkOutput("rd0_wb_valid", 32'(bus.wb_valid_o), 1);
        checkOutput("rd0_wb_rw",    32'(bus.wb_reg_write_o), 0);
        checkOutput("rd0_wb_data",  bus.wb_data_o, 32'h1234_5678);
        @(negedge clk) bus.dmem_rvalid_i = 1'b0;

        // Reset during WAIT, late response ignored
        @(negedge clk) applyStimulus(1, OP_LOAD, 3'b010, 6, 1, 0, 32'h600, 0, 0);
        tick();
        @(negedge clk);
        applyStimulus(0, '0, '0, '0, 0, 0, '0, '0, '0);
        bus.dmem_gnt_i = 1'b1;
        tick();
        checkOutput("rstw_in_wait", 32'(bus.stall_o), 1);
        @(negedge clk);
        bus.dmem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_stall", 32'(bus.stall_o), 0);
        checkOutput("rstw_req",   32'(bus.dmem_req_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dmem_rvalid_i = 1'b1;
        tick();
        checkOutput("rstw_wb_valid", 32'(bus.wb_valid_o), 0);
        checkOutput("rstw_idle",     32'(bus.stall_o), 0);
        @(negedge clk) bus.dmem_rvalid_i = 1'b0;
        tick();
        checkOutput("rstw_wb_valid2", 32'(bus.wb_valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_mem_stage.md
CORE_MEM_STAGE -- requirements
Module: core_mem_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 valid_i  in  1  EX result present this cycle.
REQ-005 opcode_i  in  7  EX-stage opcode; LOAD and STORE select memory ops.
REQ-006 funct3_i  in  3  access size and signedness.
REQ-007 rd_i  in  5  destination register.
REQ-008 reg_write_i  in  1  instruction writes rd.
REQ-009 mul_sel_i  in  1  writeback takes mul_result_i instead of alu_result_i.
REQ-010 alu_result_i  in  XLEN  ALU result; effective address for LOAD/STORE.
REQ-011 store_data_i  in  XLEN  forwarded rs2 value.
REQ-012 mul_result_i  in  XLEN  M-extension result.
REQ-013 dmem_req_o / dmem_we_o  out  1/1  request; 1 = write.
REQ-014 dmem_addr_o  out  XLEN  word-aligned address (bits 1:0 = 0).
REQ-015 dmem_be_o / dmem_wdata_o  out  4/XLEN  byte enables, lane-placed write data.
REQ-016 dmem_gnt_i / dmem_rvalid_i / dmem_rdata_i  in  1/1/XLEN  grant, response valid, read word.
REQ-017 stall_o  out  1  upstream holds its outputs while high.
REQ-018 wb_valid_o / wb_reg_write_o / wb_rd_o / wb_data_o  out  1/1/5/XLEN  registered writeback bundle.
REQ-019 misaligned_o  out  1  one-cycle pulse on a misaligned or illegal access.

Function
REQ-020 FSM states: IDLE, REQ, WAIT; stall_o SHALL equal (state != IDLE).
REQ-021 IDLE, valid_i, non-memory op: capture the writeback bundle the next edge, wb_data = mul_sel_i ? mul_result_i : alu_result_i; latency 1 cycle; state stays IDLE.
REQ-022 IDLE, valid_i, legal memory op: latch address, funct3, rd, we, wdata and be; go to REQ; wb_valid_o = 0 next cycle.
REQ-023 REQ: dmem_req_o = 1 with stable addr/we/be/wdata until a cycle with dmem_gnt_i = 1, then go to WAIT.
REQ-024 WAIT: on dmem_rvalid_i = 1, go to IDLE and register the writeback bundle; dmem_rvalid_i is ignored outside WAIT.
REQ-025 dmem_req_o SHALL be 0 in IDLE and WAIT; no second request is issued before rvalid.
REQ-026 Store size mapping: SB be = 1 << addr[1:0], byte replicated to all lanes; SH be = 0011 or 1100 by addr[1], halfword replicated; SW be = 1111.
REQ-027 Load extraction: select the lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-028 Loads drive be = 1111.
REQ-029 Misaligned cases: halfword with addr[0] = 1; word with addr[1:0] != 0.
REQ-030 Illegal funct3: loads 3, 6 or 7; stores >= 3.
REQ-031 On a misaligned or illegal access: no memory request; misaligned_o pulses the next cycle; wb_valid_o = 1 and wb_reg_write_o = 0 that cycle.
REQ-032 wb_reg_write_o SHALL be 0 whenever wb_rd_o = 0.
REQ-033 Stores complete with wb_reg_write_o = 0.
REQ-034 wb_valid_o is a one-cycle pulse per accepted instruction.
REQ-035 wb_valid_o = 0 in any cycle with no completing instruction; the wb bundle otherwise holds its last value.
REQ-036 valid_i is ignored while state != IDLE.

Reset
REQ-037 rst_ni low: state IDLE; all outputs 0, including stall_o, dmem_req_o, wb_valid_o and misaligned_o.
REQ-038 Reset asserted mid-transaction abandons it: no writeback is produced; a late dmem_rvalid_i after reset is ignored.

Verification
REQ-039 Non-mem op, alu=0x10, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x10, wb_rd=5, stall_o never high.
REQ-040 LB at addr 0x103, memory word 0x80FF_0000, gnt same cycle as req, rvalid next -> wb_data=0xFFFF_FF80; total latency 3 cycles.
REQ-041 SH at addr 0x202, data 0x1234_ABCD, gnt delayed 3 cycles -> req held 4 cycles with addr=0x200, be=1100, wdata=0xABCD_ABCD; stall_o high throughout; wb_reg_write=0.
REQ-042 LW at addr 0x101 -> no dmem_req_o, misaligned_o pulse, wb_valid=1, wb_reg_write=0.
REQ-043 Load with rd=0 -> wb_reg_write=0 after rvalid.
REQ-044 rst_ni asserted during WAIT, rvalid arrives after release -> no wb_valid, state IDLE.
